// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the SRAM responder and the manager-side
// fetch/LSU blocks.
//   - RESP_OKAY / RESP_SLVERR : xRESP encodings used by this system
//   - rd_state_t / wr_state_t : read and write channel FSM states
//   - lfsr8_step()            : one step of the 8-bit maximal-length LFSR
//                               (x^8 + x^6 + x^5 + x^4 + 1)
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Fibonacci form, shifting left; feedback taps at bits 8,6,5,4 (1-based).
    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/axi_lite_sram_lfsr8.sv
// 8-bit maximal-length LFSR used to generate per-transaction response delays.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, loads seed
//   seed  - reset value (must be non-zero, the all-zero state is a lock-up)
//   en    - advance one step this cycle
//   state - current LFSR value
module lfsr8
    import axi_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] state
);

    logic [7:0] state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= seed;
        end else if (en) begin
            state_reg <= lfsr8_step(state_reg);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite responder backed by a word-addressed memory, with independent
// read and write channel FSMs and a pseudo-random response latency per
// transaction (0..DELAY_MASK extra cycles) to stress manager handshakes.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   araddr/arvalid/arready            - read address channel
//   rdata/rresp/rvalid/rready         - read data channel
//   awaddr/awvalid/awready            - write address channel
//   wdata/wstrb/wvalid/wready         - write data channel
//   bresp/bvalid/bready               - write response channel
// Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) answer SLVERR;
// out-of-range reads return zero data and writes leave memory untouched.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           DEPTH_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h80000000,
    parameter bit                    RANDOM_DELAY = 1'b1,
    parameter logic [7:0]            DELAY_MASK   = 8'h1f,
    parameter logic [7:0]            LFSR_SEED    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned           IDX_WIDTH  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);

    // The lower-bound test keeps addresses below BASE_ADDR from wrapping
    // into range through the subtraction.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN_BYTES);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_WIDTH'(off >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Delay generation: one LFSR per channel so read and write latencies
    // are uncorrelated. The write seed is a nibble swap of the read seed,
    // which stays non-zero whenever LFSR_SEED is non-zero.
    // ------------------------------------------------------------------
    logic [7:0] rd_lfsr;
    logic [7:0] wr_lfsr;
    logic [7:0] rd_delay;
    logic [7:0] wr_delay;

    lfsr8 u_rd_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .en    (1'b1),
        .state (rd_lfsr)
    );

    lfsr8 u_wr_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  ({LFSR_SEED[3:0], LFSR_SEED[7:4]}),
        .en    (1'b1),
        .state (wr_lfsr)
    );

    assign rd_delay = RANDOM_DELAY ? (rd_lfsr & DELAY_MASK) : 8'd0;
    assign wr_delay = RANDOM_DELAY ? (wr_lfsr & DELAY_MASK) : 8'd0;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t             rd_state_reg, rd_state_next;
    logic [7:0]            rd_cnt_reg, rd_cnt_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic                  rd_ok_reg, rd_ok_next;
    logic                  rd_sample;
    logic                  rd_in_range;
    logic [IDX_WIDTH-1:0]  rd_idx;

    assign rd_in_range = addr_in_range(rd_addr_reg);
    assign rd_idx      = addr_index(rd_addr_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg <= R_IDLE;
            rd_cnt_reg   <= '0;
            rd_addr_reg  <= '0;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= RESP_OKAY;
            rd_ok_reg    <= 1'b0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_addr_reg  <= rd_addr_next;
            arready_reg  <= arready_next;
            rvalid_reg   <= rvalid_next;
            rresp_reg    <= rresp_next;
            rd_ok_reg    <= rd_ok_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_addr_next  = rd_addr_reg;
        arready_next  = arready_reg;
        rvalid_next   = rvalid_reg;
        rresp_next    = rresp_reg;
        rd_ok_next    = rd_ok_reg;
        rd_sample     = 1'b0;

        unique case (rd_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (arvalid && arready_reg) begin
                    rd_addr_next  = araddr;
                    rd_cnt_next   = rd_delay;
                    arready_next  = 1'b0;
                    rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_reg == 8'd0) begin
                    // Memory is only touched for in-range addresses; rd_ok
                    // forces rdata to zero for the SLVERR case.
                    rd_sample     = rd_in_range;
                    rd_ok_next    = rd_in_range;
                    rresp_next    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rvalid_next   = 1'b1;
                    rd_state_next = R_RESP;
                end else begin
                    rd_cnt_next = rd_cnt_reg - 8'd1;
                end
            end
            R_RESP: begin
                if (rvalid_reg && rready) begin
                    rvalid_next   = 1'b0;
                    arready_next  = 1'b1;
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t             wr_state_reg, wr_state_next;
    logic [7:0]            wr_cnt_reg, wr_cnt_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic [STRB_WIDTH-1:0] wr_strb_reg, wr_strb_next;
    logic                  aw_held_reg, aw_held_next;
    logic                  w_held_reg, w_held_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic                  wr_fire;
    logic                  wr_commit;
    logic                  wr_in_range;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_have;
    logic                  w_have;

    assign wr_in_range = addr_in_range(wr_addr_reg);
    assign wr_idx      = addr_index(wr_addr_reg);
    assign aw_hs       = awvalid && awready_reg;
    assign w_hs        = wvalid && wready_reg;
    assign aw_have     = aw_held_reg || aw_hs;
    assign w_have      = w_held_reg || w_hs;
    // A reset in the commit cycle must abort the write.
    assign wr_commit   = wr_fire && wr_in_range && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            wr_cnt_reg   <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            wr_strb_reg  <= '0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            wr_cnt_reg   <= wr_cnt_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            wr_strb_reg  <= wr_strb_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_cnt_next   = wr_cnt_reg;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        wr_strb_next  = wr_strb_reg;
        aw_held_next  = aw_held_reg;
        w_held_next   = w_held_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        wr_fire       = 1'b0;

        unique case (wr_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    wr_addr_next = awaddr;
                end
                if (w_hs) begin
                    wr_data_next = wdata;
                    wr_strb_next = wstrb;
                end
                if (aw_have && w_have) begin
                    aw_held_next  = 1'b0;
                    w_held_next   = 1'b0;
                    awready_next  = 1'b0;
                    wready_next   = 1'b0;
                    wr_cnt_next   = wr_delay;
                    wr_state_next = W_WAIT;
                end else begin
                    // Each half is taken once; its ready stays low until
                    // the other half arrives and the response completes.
                    aw_held_next = aw_have;
                    w_held_next  = w_have;
                    awready_next = !aw_have;
                    wready_next  = !w_have;
                end
            end
            W_WAIT: begin
                if (wr_cnt_reg == 8'd0) begin
                    wr_fire       = 1'b1;
                    bresp_next    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    bvalid_next   = 1'b1;
                    wr_state_next = W_RESP;
                end else begin
                    wr_cnt_next = wr_cnt_reg - 8'd1;
                end
            end
            W_RESP: begin
                if (bvalid_reg && bready) begin
                    bvalid_next   = 1'b0;
                    awready_next  = 1'b1;
                    wready_next   = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane so byte strobes map directly to
    // per-lane write enables. Read and write share a clocked block, so a
    // same-cycle read of the word being written returns the old contents.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;

    genvar gi;
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (wr_commit && wr_strb_reg[gi]) begin
                mem[wr_idx] <= wr_data_reg[gi*8 +: 8];
            end
            if (rd_sample) begin
                q_reg <= mem[rd_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = q_reg;
    end

    assign arready = arready_reg;
    assign rdata   = rd_ok_reg ? rd_word : '0;
    assign rresp   = rresp_reg;
    assign rvalid  = rvalid_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bresp   = bresp_reg;
    assign bvalid  = bvalid_reg;

endmodule
